// File: rtl/ins_fetch_seq.sv
// Instruction fetch sequencer: owns the PC, drives the IRAM read port and emits a
// single-cycle MBRU fetch strobe once the IRAM read latency has elapsed.
module ins_fetch_seq #(
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       IRAM_LAT   = 1,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  // ins_cnt value after reset; nonzero only to preload the counter near saturation
  parameter logic [15:0]       CNT_RESET  = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              next_req,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] iram_addr,
  output logic              iram_en,
  output logic              fetch,
  output logic              ins_ready,
  output logic              busy,
  output logic [15:0]       ins_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WAIT   = 3'd2,
    S_FETCH  = 3'd3,
    S_HOLD   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  // WAIT covers latency cycles beyond the ADDR cycle; the last WAIT cycle has count 0
  localparam logic [1:0] LAT_LOAD = 2'((IRAM_LAT > 1) ? (IRAM_LAT - 2) : 0);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_lat_cnt;
  logic [15:0]       r_ins_cnt;

  state_t            w_state_next;
  logic [ADDR_W-1:0] w_pc_next;
  logic [1:0]        w_lat_next;
  logic [15:0]       w_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= START_ADDR;
      r_lat_cnt <= 2'd0;
      r_ins_cnt <= CNT_RESET;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_lat_cnt <= w_lat_next;
      r_ins_cnt <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_lat_next   = r_lat_cnt;
    w_cnt_next   = r_ins_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_ADDR;
      end
      S_ADDR: begin
        if (IRAM_LAT == 1) begin
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_WAIT;
          w_lat_next   = LAT_LOAD;
        end
      end
      S_WAIT: begin
        if (r_lat_cnt == 2'd0) w_state_next = S_FETCH;
        else                   w_lat_next   = r_lat_cnt - 2'd1;
      end
      S_FETCH: begin
        w_state_next = S_HOLD;
        w_pc_next    = r_pc + ADDR_W'(1);
        if (r_ins_cnt != 16'hFFFF) w_cnt_next = r_ins_cnt + 16'd1;
      end
      S_HOLD: begin
        if (halt) begin
          w_state_next = S_HALTED;
        end else if (jump) begin
          w_state_next = S_ADDR;
          w_pc_next    = jump_addr;
        end else if (next_req) begin
          w_state_next = S_ADDR;
        end
      end
      S_HALTED: begin
        if (start) w_state_next = S_ADDR;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign iram_addr = r_pc;
  assign iram_en   = (r_state == S_ADDR);
  assign fetch     = (r_state == S_FETCH);
  assign ins_ready = (r_state == S_HOLD);
  assign busy      = (r_state == S_ADDR) || (r_state == S_WAIT) || (r_state == S_FETCH);
  assign ins_cnt   = r_ins_cnt;

endmodule
